// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for sequential datapath controllers.
//   state_t   - controller state encoding (IDLE, LOAD, ADD, SHIFT, DONE)
//   cnt_width - width of a bits-remaining counter able to hold the value w
package mul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mul_sequencer_reg.sv
// mul_sequencer_reg: general-purpose register with clear, load,
// increment, decrement and serial shift controls.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset (clears q)
//   cl            - synchronous clear (highest priority)
//   ld, d         - parallel load of d
//   inc, dec      - count up / count down by one
//   sr, sr_in     - shift right, sr_in enters at the MSB
//   sl, sl_in     - shift left, sl_in enters at the LSB
//   q             - register contents
// Controls are prioritised cl > ld > inc > dec > sr > sl.
module mul_sequencer_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cl,
  input  logic         ld,
  input  logic         inc,
  input  logic         dec,
  input  logic         sr,
  input  logic         sl,
  input  logic         sr_in,
  input  logic         sl_in,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (cl)  q <= '0;
    else if (ld)  q <= d;
    else if (inc) q <= q + W'(1);
    else if (dec) q <= q - W'(1);
    else if (sr)  q <= {sr_in, q[W-1:1]};
    else if (sl)  q <= {q[W-2:0], sl_in};
  end

endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: unsigned shift-and-add multiplier with valid/ready
// handshakes on both sides and a fixed 2*DATA_WIDTH+2 cycle latency.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   abort               - synchronous cancel, returns to IDLE next edge
//   in_valid, in_ready  - operand handshake (a, b)
//   a, b                - unsigned multiplicand / multiplier
//   out_valid, out_ready- result handshake
//   product             - a*b, meaningful while out_valid=1
//   busy                - high whenever not IDLE
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// LOAD  | clear A and C, preset CNT to DATA_WIDTH
// ADD   | {C,A} <= A+M when Q[0]=1, else hold (visited every bit)
// SHIFT | {C,A,Q} >>= 1, CNT-1; leave for DONE when CNT reaches 0
// DONE  | product held with out_valid=1 until out_ready
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    abort,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic                    busy
);

  localparam int CW = cnt_width(DATA_WIDTH);

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] m_q, a_q, q_q;
  logic [CW-1:0]         cnt_q;
  logic                  c_q;
  logic [DATA_WIDTH:0]   sum;

  logic m_ld, q_ld, q_sr, a_cl, a_ld, a_sr, cnt_ld, cnt_dec;
  logic c_ld, c_d;

  assign sum = {1'b0, a_q} + {1'b0, m_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    m_ld      = 1'b0;
    q_ld      = 1'b0;
    q_sr      = 1'b0;
    a_cl      = 1'b0;
    a_ld      = 1'b0;
    a_sr      = 1'b0;
    cnt_ld    = 1'b0;
    cnt_dec   = 1'b0;
    c_ld      = 1'b0;
    c_d       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && !abort) begin
          m_ld      = 1'b1;
          q_ld      = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        a_cl      = 1'b1;
        cnt_ld    = 1'b1;
        c_ld      = 1'b1;
        state_nxt = ST_ADD;
      end
      ST_ADD: begin
        if (q_q[0]) begin
          a_ld = 1'b1;
          c_ld = 1'b1;
          c_d  = sum[DATA_WIDTH];
        end
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        a_sr      = 1'b1;
        q_sr      = 1'b1;
        cnt_dec   = 1'b1;
        c_ld      = 1'b1;
        // cnt_q is the pre-decrement value, so 1 means this was the last bit
        state_nxt = (cnt_q == CW'(1)) ? ST_DONE : ST_ADD;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // abort wins over everything; registers left as-is are reloaded on the next start
    if (abort) begin
      state_nxt = ST_IDLE;
      m_ld      = 1'b0;
      q_ld      = 1'b0;
      q_sr      = 1'b0;
      a_cl      = 1'b0;
      a_ld      = 1'b0;
      a_sr      = 1'b0;
      cnt_ld    = 1'b0;
      cnt_dec   = 1'b0;
      c_ld      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    c_q <= 1'b0;
    else if (c_ld) c_q <= c_d;
  end

  mul_sequencer_reg #(.W(DATA_WIDTH)) u_m (
    .clk(clk), .rst_n(rst_n), .cl(1'b0), .ld(m_ld), .inc(1'b0), .dec(1'b0),
    .sr(1'b0), .sl(1'b0), .sr_in(1'b0), .sl_in(1'b0), .d(a), .q(m_q)
  );

  mul_sequencer_reg #(.W(DATA_WIDTH)) u_a (
    .clk(clk), .rst_n(rst_n), .cl(a_cl), .ld(a_ld), .inc(1'b0), .dec(1'b0),
    .sr(a_sr), .sl(1'b0), .sr_in(c_q), .sl_in(1'b0),
    .d(sum[DATA_WIDTH-1:0]), .q(a_q)
  );

  mul_sequencer_reg #(.W(DATA_WIDTH)) u_q (
    .clk(clk), .rst_n(rst_n), .cl(1'b0), .ld(q_ld), .inc(1'b0), .dec(1'b0),
    .sr(q_sr), .sl(1'b0), .sr_in(a_q[0]), .sl_in(1'b0), .d(b), .q(q_q)
  );

  mul_sequencer_reg #(.W(CW)) u_cnt (
    .clk(clk), .rst_n(rst_n), .cl(1'b0), .ld(cnt_ld), .inc(1'b0), .dec(cnt_dec),
    .sr(1'b0), .sl(1'b0), .sr_in(1'b0), .sl_in(1'b0),
    .d(CW'(DATA_WIDTH)), .q(cnt_q)
  );

  assign product = {a_q, q_q};

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: self-checking bench for mul_sequencer (DATA_WIDTH=16).
// Reference: product = a*b, result first sampled valid 2*W+2 edges after
// the accepting edge, held until out_ready, aborts/resets discard work.
module tb_mul_sequencer;

  localparam int W   = 16;
  localparam int LAT = 2 * W + 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           abort = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           in_ready;
  logic           out_valid;
  logic           busy;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_errors = 0;

  mul_sequencer #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("ready_before_op", 64'(in_ready), 64'(1));
  endtask

  // Full transaction: accept, count latency, hold in DONE, release.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input int hold, input bit noise);
    logic [2*W-1:0] exp, held;
    int  lat;
    bit  busy_ok, stable;
    exp = (2*W)'(oa) * (2*W)'(ob);
    wait_ready();
    a = oa;
    b = ob;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      if (!busy || in_ready) busy_ok = 1'b0;
      if (noise) begin
        out_ready = 1'($urandom_range(0, 1));
        in_valid  = 1'($urandom_range(0, 1));
        a = W'($urandom);
        b = W'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("latency", 64'(lat), 64'(LAT));
    check("busy_during_op", 64'(busy_ok), 64'(1));
    check("busy_in_done", 64'(busy), 64'(1));
    check("product", 64'(product), 64'(exp));
    held = product;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a = W'($urandom);
        b = W'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      if (!out_valid || product !== held || in_ready) stable = 1'b0;
    end
    check("hold_stable", 64'(stable), 64'(1));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release_in_ready", 64'(in_ready), 64'(1));
    check("release_out_valid", 64'(out_valid), 64'(0));
  endtask

  // Start an operation, abort it after k more edges with in_valid also high.
  task automatic abort_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input int k);
    bit quiet;
    wait_ready();
    a = oa;
    b = ob;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < k; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    abort = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    in_valid = 1'b0;
    check("abort_idle_busy", 64'(busy), 64'(0));
    check("abort_idle_ready", 64'(in_ready), 64'(1));
    check("abort_out_valid", 64'(out_valid), 64'(0));
    quiet = 1'b1;
    for (int i = 0; i < LAT + 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid || busy) quiet = 1'b0;
    end
    check("abort_stays_idle", 64'(quiet), 64'(1));
  endtask

  initial begin
    bit quiet;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_product", 64'(product), 64'(0));
    rst_n = 1'b1;

    run_op(16'h0003, 16'h0005, 0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 0, 1'b0);
    run_op(16'h1234, 16'h0000, 0, 1'b0);
    run_op(16'h0000, 16'hABCD, 0, 1'b0);
    run_op(16'h8001, 16'hC003, 10, 1'b1);

    // abort while idle blocks the simultaneous start
    @(negedge clk);
    a = 16'h0011;
    b = 16'h0022;
    abort = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    in_valid = 1'b0;
    check("idle_abort_no_accept", 64'(busy), 64'(0));

    abort_op(16'h00FF, 16'h0F0F, 10);

    // reset pulsed at edge 20 of an operation
    wait_ready();
    a = 16'h4321;
    b = 16'h1111;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_product", 64'(product), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < LAT + 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid || busy) quiet = 1'b0;
    end
    check("midrst_no_result", 64'(quiet), 64'(1));
    run_op(16'd7, 16'd9, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 4) == 0)
        abort_op(ra, rb, int'($urandom_range(1, LAT - 1)));
      else
        run_op(ra, rb, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
